// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared types and constants for the seven-segment scan controller
package seven_seg_pkg;

    localparam int HEX_W      = 4;
    localparam int MAX_DIGITS = 32;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    // Active-low anodes: a set bit means the digit is dark.
    function automatic logic [MAX_DIGITS-1:0] anodes_off_mask(input int num_digits);
        logic [MAX_DIGITS-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < num_digits) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/seven_seg_frame_buf.sv
// rtl/seven_seg_frame_buf.sv - shadow/active digit double buffer with pending flag
module seven_seg_frame_buf
    import seven_seg_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [DATA_W-1:0] digits_in,
    input  logic              commit,
    output logic [DATA_W-1:0] active_out,
    output logic [DATA_W-1:0] active_nxt,
    output logic              pending
);

    logic [DATA_W-1:0] shadow;

    // Lets the scanner register hex_out with the value that becomes active at this edge.
    assign active_nxt = (commit && pending) ? shadow : active_out;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shadow     <= '0;
            active_out <= '0;
            pending    <= 1'b0;
        end else begin
            if (commit && pending) begin
                active_out <= shadow;
            end
            // A load on the commit edge keeps pending so the new data waits a frame.
            if (load) begin
                shadow  <= digits_in;
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - multiplexed 7-seg digit scanner; SEVEN_SEG_SCAN_DIM_EN adds brightness dimming
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 2,
    parameter int DWELL_CYCLES = 24000,
    parameter int BLANK_CYCLES = 240
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        load,
    input  logic [HEX_W*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]       digit_en,
`ifdef SEVEN_SEG_SCAN_DIM_EN
    input  logic [3:0]                  brightness,
`endif
    output logic [HEX_W-1:0]            hex_out,
    output logic [NUM_DIGITS-1:0]       anodes_n,
    output logic                        frame_tick,
    output logic                        pending
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int DATA_W  = HEX_W * NUM_DIGITS;

    localparam logic [CNT_W-1:0]      DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ANODES_OFF = NUM_DIGITS'(anodes_off_mask(NUM_DIGITS));

    scan_state_t       state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic              frame_end;
    logic              lit_nxt;
    logic [NUM_DIGITS-1:0] anode_sel;
    logic [DATA_W-1:0] active, active_nxt;

    seven_seg_frame_buf #(
        .DATA_W (DATA_W)
    ) u_frame_buf (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load),
        .digits_in  (digits_in),
        .commit     (frame_end),
        .active_out (active),
        .active_nxt (active_nxt),
        .pending    (pending)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        idx_nxt   = idx;
        frame_end = 1'b0;
        case (state)
            BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_nxt = SHOW;
                    cnt_nxt   = '0;
                end
            end
            SHOW: begin
                if (cnt == DWELL_LAST) begin
                    state_nxt = BLANK;
                    cnt_nxt   = '0;
                    if (idx == IDX_LAST) begin
                        idx_nxt   = '0;
                        frame_end = 1'b1;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = BLANK;
                cnt_nxt   = '0;
                idx_nxt   = '0;
            end
        endcase
    end

    // Disabled or dimmed digits still consume their full slot so brightness stays uniform.
`ifdef SEVEN_SEG_SCAN_DIM_EN
    logic [31:0] dim_limit;
    assign dim_limit = ((32'(brightness) + 32'd1) * 32'(DWELL_CYCLES)) >> 4;
    assign lit_nxt   = (state_nxt == SHOW) && digit_en[idx_nxt] && (32'(cnt_nxt) < dim_limit);
`else
    assign lit_nxt   = (state_nxt == SHOW) && digit_en[idx_nxt];
`endif

    assign anode_sel = ANODES_OFF & ~(NUM_DIGITS'(1) << idx_nxt);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= BLANK;
            cnt        <= '0;
            idx        <= '0;
            anodes_n   <= ANODES_OFF;
            hex_out    <= '0;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            anodes_n   <= lit_nxt ? anode_sel : ANODES_OFF;
            hex_out    <= active_nxt[idx_nxt*HEX_W +: HEX_W];
            frame_tick <= frame_end;
        end
    end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
- Time-multiplexes one shared hex-to-7-segment decoder across NUM_DIGITS common-anode digits.
- Drives the 4-bit hex input of the decoder and active-low per-digit anode enables.
- Inserts a blanking interval between digits to suppress ghosting.
- Double-buffers incoming digit values so a display update never tears mid-frame. Sits between keypad/data logic and the decoder in the display path.

Parameters:
- NUM_DIGITS, 2: digits scanned; ≥2.
- DWELL_CYCLES, 24000: clk cycles each digit slot is lit (SHOW length); ≥2.
- BLANK_CYCLES, 240: clk cycles all anodes are off before each slot; ≥1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- load  in  1  one-cycle strobe; capture digits_in into shadow.
- digits_in  in  4*NUM_DIGITS  digit i = bits [4i+3:4i]; digit 0 scanned first.
- digit_en  in  NUM_DIGITS  per-digit enable; sampled live, not buffered.
- hex_out  out  4  to decoder hex input.
- anodes_n  out  NUM_DIGITS  active-low digit enables.
- frame_tick  out  1  one-cycle pulse at each frame boundary.
- pending  out  1  shadow holds data not yet displayed.

Behaviour:
- Reset and clock:
  - One clock; reset is synchronous and active-low. All state updates on rising clk.
  - When reset_n=0 on an edge: state=BLANK, idx=0, cnt=0, anodes_n=all 1, hex_out=0, frame_tick=0, pending=0, shadow=0, active=0.
  - Reset mid-slot aborts the slot immediately. Scanning restarts from BLANK, idx 0.
- State machine (BLANK, SHOW), cnt counts slot cycles:
  - BLANK: anodes_n all 1. hex_out = active digit idx, presented early so the decoder settles. Stays BLANK_CYCLES cycles, then goes to SHOW with cnt=0.
  - SHOW: anodes_n[idx]=0 if digit_en[idx], else all 1. A disabled digit keeps its slot time, so brightness stays uniform. hex_out = active digit idx. Stays DWELL_CYCLES cycles, then goes to BLANK with cnt=0 and idx=idx+1.
  - idx wraps from NUM_DIGITS-1 to 0.
- Frame period = NUM_DIGITS*(BLANK_CYCLES+DWELL_CYCLES) cycles.
- All outputs are registered. Output values reflect the state entered at that edge.
- Frame boundary is the SHOW→BLANK edge where idx wraps to 0. On that edge:
  - frame_tick=1 for exactly that cycle.
  - If pending=1, active<=shadow and pending<=0.
- load handling:
  - load=1: shadow<=digits_in, pending<=1.
  - load while pending=1: shadow is overwritten; latest value wins.
  - load coincident with the frame boundary: the commit uses the pre-edge shadow. The new value lands in shadow, pending stays 1, and it commits at the next boundary.
- First frame after reset displays active=0 ("0" on enabled digits). Data loaded during frame 0 first appears at frame 1, idx 0.
- digit_en change takes effect on the next edge. It never alters timing.
- Counter width: $clog2(max(DWELL_CYCLES,BLANK_CYCLES)). idx width: $clog2(NUM_DIGITS).

Optional Feature:
- Macro: SEVEN_SEG_SCAN_DIM_EN.
- Defined:
  - Adds input port brightness[3:0].
  - During SHOW, the anode is asserted only while cnt < ((brightness+1)*DWELL_CYCLES)>>4, computed at width sufficient to avoid overflow.
  - brightness=15 gives full dwell. brightness=0 gives DWELL_CYCLES/16.
  - brightness is sampled each cycle. Slot timing is unchanged.
- Undefined: no port; anode lit for the full SHOW.

Decomposition:
- Package seven_seg_pkg:
  - scan_state_t enum {BLANK, SHOW}.
  - Constant HEX_W=4.
  - Blank/all-off anode constant function.
- Sub-module seven_seg_frame_buf holds shadow/active registers and the pending flag. Ports: load, digits_in, commit, active_out, pending.
- The decoder is instantiated beside this block at top level, not inside.

Test Plan (NUM_DIGITS=2, DWELL_CYCLES=4, BLANK_CYCLES=1):
- Reset release, digit_en=2'b11, no load:
  - Sequence from reset is BLANK(1 cycle), SHOW idx0 (4 cycles, anodes_n=2'b10, hex_out=0), BLANK(1), SHOW idx1 (anodes_n=2'b01).
  - frame_tick pulses on cycle 10 and every 10 cycles after.
- load with digits_in=8'h3A mid-frame 0:
  - pending=1 until the boundary.
  - Then SHOW idx0 gives hex_out=A and SHOW idx1 gives hex_out=3; pending=0.
- load 8'h12 then 8'h34 within one frame: only 34 is displayed after the boundary.
- load 8'h56 coincident with frame_tick:
  - Prior shadow commits.
  - 56 displays one frame later; pending stays 1 across the boundary.
- digit_en=2'b01: digit 1 slot keeps anodes_n=2'b11 for 4 cycles; frame period is still 10.
- reset_n low during SHOW idx1: next cycle anodes_n=2'b11, hex_out=0, pending=0. Restart matches the first scenario.
